fu_mult_param: RTL and testbench

- Parametrised pipelined multiply functional unit for the OoO core. Executes RV32M mul/mulh/mulhsu/mulhu from a reservation-station issue packet and delivers the result as a cdb_t broadcast.
- Successor to the fixed 3-deep multiplier. Adds configurable depth, a valid/ready handshake on both sides, CDB back-pressure with per-stage bubble collapsing, and flush-safe kill.
- Sits between the mult reservation station and the CDB arbiter.

---
 rtl/fu_mult_param.sv | 196 +++++++++++++++++++
 tb/tb_fu_mult_param.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fu_mult_param.sv
// Parametrised pipelined RV32M multiply unit: RS issue packet in, CDB broadcast out, with
// back-pressure bubble collapsing and flush kill. `define FU_MULT_PERF_CNT_EN adds perf counters.
package types;
  localparam int ROB_TAG_W = 5;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] pc_rdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
  } rvfi_t;

  typedef struct packed {
    logic                 valid;
    logic [2:0]           muldiv_op;
    logic [31:0]          rs1_v;
    logic [31:0]          rs2_v;
    logic [ROB_TAG_W-1:0] rob_tag;
    rvfi_t                rvfi;
  } fu_pkt_t;

  typedef struct packed {
    logic                 valid;
    logic [31:0]          data;
    logic [ROB_TAG_W-1:0] rob_tag;
    logic [31:0]          rs1_data;
    logic [31:0]          rs2_data;
    logic                 br_taken;
    logic [31:0]          br_target;
    rvfi_t                rvfi;
  } cdb_t;
endpackage

// One pipeline slot: valid bit plus payload, loaded whenever the slot is free.
module fu_mult_stage
  import types::*;
(
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic load,
  input  logic in_vld,
  input  cdb_t d,
  output logic vld,
  output cdb_t q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= 1'b0;
      q   <= '0;
    end else begin
      if (flush)     vld <= 1'b0;
      else if (load) vld <= in_vld;
      if (load && in_vld && !flush) q <= d;
    end
  end
endmodule

module fu_mult_param
  import types::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int XLEN       = 32
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    flush,
  input  fu_pkt_t mult_pkt_in,
  output logic    in_ready,
  output cdb_t    mult_out,
`ifdef FU_MULT_PERF_CNT_EN
  input  logic        out_ready,
  output logic [31:0] perf_ops,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_flushed
`else
  input  logic    out_ready
`endif
);
  logic [NUM_STAGES-1:0] vld_pipe;
  logic [NUM_STAGES-1:0] free;
  logic [NUM_STAGES-1:0] stg_in;
  cdb_t                  stg_d [NUM_STAGES];
  cdb_t                  stg_q [NUM_STAGES];
  logic                  accept;

  // ---- arithmetic ahead of stage 0 ----
  logic                    a_sgn, b_sgn;
  logic signed [XLEN:0]    a_ext, b_ext;
  logic signed [2*XLEN+1:0] prod;
  logic [1:0]              unused_prod_hi;
  logic [XLEN-1:0]         res;
  cdb_t                    s0_pkt;

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (mult_pkt_in.muldiv_op)
      MD_MUL, MD_MULH: begin a_sgn = 1'b1; b_sgn = 1'b1; end
      MD_MULHSU:       a_sgn = 1'b1;
      default: ;
    endcase
  end

  assign a_ext          = {a_sgn & mult_pkt_in.rs1_v[XLEN-1], mult_pkt_in.rs1_v};
  assign b_ext          = {b_sgn & mult_pkt_in.rs2_v[XLEN-1], mult_pkt_in.rs2_v};
  assign prod           = a_ext * b_ext;
  assign unused_prod_hi = prod[2*XLEN+1:2*XLEN];

  always_comb begin
    res = '0;
    case (mult_pkt_in.muldiv_op)
      MD_MUL:                     res = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: res = prod[2*XLEN-1:XLEN];
      default: ;
    endcase
  end

  always_comb begin
    s0_pkt               = '0;
    s0_pkt.valid         = 1'b1;
    s0_pkt.data          = res;
    s0_pkt.rob_tag       = mult_pkt_in.rob_tag;
    s0_pkt.rs1_data      = mult_pkt_in.rs1_v;
    s0_pkt.rs2_data      = mult_pkt_in.rs2_v;
    s0_pkt.rvfi          = mult_pkt_in.rvfi;
    s0_pkt.rvfi.rd_wdata = res;
  end

  // ---- movement: a slot is free if empty or its occupant moves on ----
  // The chain runs from out_ready back to stage 0 through valid bits only.
  always_comb begin
    logic ok;
    ok   = out_ready;
    free = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      free[i] = !vld_pipe[i] || ok;
      ok      = free[i];
    end
  end

  assign in_ready = free[0];
  assign accept   = mult_pkt_in.valid && in_ready && !flush;

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stg
    if (g == 0) begin : g_head
      assign stg_d[g]  = s0_pkt;
      assign stg_in[g] = accept;
    end else begin : g_body
      assign stg_d[g]  = stg_q[g-1];
      assign stg_in[g] = vld_pipe[g-1] && free[g];
    end

    fu_mult_stage u_stage (
      .clk    (clk),
      .rst    (rst),
      .flush  (flush),
      .load   (free[g]),
      .in_vld (stg_in[g]),
      .d      (stg_d[g]),
      .vld    (vld_pipe[g]),
      .q      (stg_q[g])
    );
  end

  always_comb begin
    mult_out       = stg_q[NUM_STAGES-1];
    mult_out.valid = vld_pipe[NUM_STAGES-1];
  end

`ifdef FU_MULT_PERF_CNT_EN
  // A result handshaking on the flush edge counts as delivered, not killed.
  logic        hs;
  logic [31:0] kill_cnt;

  assign hs       = vld_pipe[NUM_STAGES-1] && out_ready;
  assign kill_cnt = 32'($countones(vld_pipe)) - {31'd0, hs};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_ops     <= '0;
      perf_stall   <= '0;
      perf_flushed <= '0;
    end else begin
      if (accept)                                   perf_ops     <= perf_ops + 32'd1;
      if (vld_pipe[NUM_STAGES-1] && !out_ready)     perf_stall   <= perf_stall + 32'd1;
      if (flush)                                    perf_flushed <= perf_flushed + kill_cnt;
    end
  end
`endif
endmodule

// File: tb/tb_fu_mult_param.sv
// Randomised + directed bench for fu_mult_param (NUM_STAGES=3) against a queue-based model.
module tb_fu_mult_param;
  import types::*;

  localparam int NS = 3;

  logic    clk = 1'b0;
  logic    rst;
  logic    flush;
  logic    in_ready;
  logic    out_ready;
  fu_pkt_t mult_pkt_in;
  cdb_t    mult_out;
`ifdef FU_MULT_PERF_CNT_EN
  logic [31:0] perf_ops, perf_stall, perf_flushed;
  int m_ops = 0, m_stall = 0, m_fl = 0, m_inflight = 0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fu_mult_param #(.NUM_STAGES(NS), .XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .mult_pkt_in (mult_pkt_in),
    .in_ready    (in_ready),
    .mult_out    (mult_out),
`ifdef FU_MULT_PERF_CNT_EN
    .out_ready   (out_ready),
    .perf_ops    (perf_ops),
    .perf_stall  (perf_stall),
    .perf_flushed(perf_flushed)
`else
    .out_ready   (out_ready)
`endif
  );

`ifdef FU_MULT_PERF_CNT_EN
  // Counter model: ops accepted, stall cycles, and ops in flight discarded by a flush.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ops = 0; m_stall = 0; m_fl = 0; m_inflight = 0;
    end else begin
      int acc, hs;
      acc = (mult_pkt_in.valid && in_ready && !flush) ? 1 : 0;
      hs  = (mult_out.valid && out_ready) ? 1 : 0;
      m_ops += acc;
      if (mult_out.valid && !out_ready) m_stall++;
      if (flush) begin m_fl += m_inflight - hs; m_inflight = 0; end
      else m_inflight += acc - hs;
    end
  end
`endif

  function automatic logic [31:0] ref_mul(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = 64'd0;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: p = sa * sb;
      3'd2: p = sa * ub;
      3'd3: p = ua * ub;
      default: return 32'd0;
    endcase
    return p[63:32];
  endfunction

  function automatic fu_pkt_t mk_pkt(logic [2:0] op, logic [31:0] a, logic [31:0] b, logic [4:0] tag);
    fu_pkt_t p;
    p               = '0;
    p.valid         = 1'b1;
    p.muldiv_op     = op;
    p.rs1_v         = a;
    p.rs2_v         = b;
    p.rob_tag       = tag;
    p.rvfi.insn     = $urandom;
    p.rvfi.pc_rdata = $urandom;
    p.rvfi.rd_addr  = 5'($urandom);
    p.rvfi.rd_wdata = $urandom;
    return p;
  endfunction

  function automatic cdb_t exp_of(fu_pkt_t p);
    cdb_t e;
    e               = '0;
    e.valid         = 1'b1;
    e.data          = ref_mul(p.muldiv_op, p.rs1_v, p.rs2_v);
    e.rob_tag       = p.rob_tag;
    e.rs1_data      = p.rs1_v;
    e.rs2_data      = p.rs2_v;
    e.rvfi          = p.rvfi;
    e.rvfi.rd_wdata = e.data;
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; mult_pkt_in = '0;
    tick(); tick();
    mult_pkt_in = mk_pkt(3'd0, 32'd3, 32'd4, 5'd1);
    #1;
    n_tests++; if (mult_out !== '0) begin n_fail++; $display("FAIL rst_out: got %h want 0", mult_out); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_inready: got %b want 1", in_ready); end
    tick();
    mult_pkt_in.valid = 1'b0;
    rst = 1'b0;
    tick();
    n_tests++; if (mult_out.valid !== 1'b0) begin n_fail++; $display("FAIL rst_release: got %b want 0", mult_out.valid); end
  endtask

  task automatic test_directed();
    logic [2:0]  ops [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5};
    logic [31:0] as  [5] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678};
    logic [31:0] bs  [5] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd9};
    logic [31:0] ks  [5] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      fu_pkt_t p;
      cdb_t    e;
      p = mk_pkt(ops[i], as[i], bs[i], 5'(i + 8));
      e = exp_of(p);
      mult_pkt_in = p;
      tick();
      mult_pkt_in.valid = 1'b0;
      tick();
      n_tests++; if (mult_out.valid !== 1'b0) begin n_fail++; $display("FAIL dir_early[%0d]: got %b want 0", i, mult_out.valid); end
      tick();
      n_tests++; if (mult_out !== e) begin n_fail++; $display("FAIL dir_result[%0d]: got %h want %h", i, mult_out, e); end
      n_tests++; if (mult_out.data !== ks[i]) begin n_fail++; $display("FAIL dir_const[%0d]: got %h want %h", i, mult_out.data, ks[i]); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    cdb_t ev [5];
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c < 5) begin
        fu_pkt_t p;
        p = mk_pkt(3'($urandom_range(0, 3)), pick(), pick(), 5'(c + 1));
        ev[c] = exp_of(p);
        mult_pkt_in = p;
      end else mult_pkt_in.valid = 1'b0;
      #1;
      if (c < 5) begin
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_inready[%0d]: got %b want 1", c, in_ready); end
      end
      if (c >= NS && c < NS + 5) begin
        n_tests++; if (mult_out !== ev[c-NS]) begin n_fail++; $display("FAIL b2b_out[%0d]: got %h want %h", c, mult_out, ev[c-NS]); end
      end else begin
        n_tests++; if (mult_out.valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle[%0d]: got %b want 0", c, mult_out.valid); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    fu_pkt_t ps [4];
    cdb_t    ev [4];
    int k = 0, got = 0;
    for (int i = 0; i < 4; i++) begin
      ps[i] = mk_pkt(3'($urandom_range(0, 3)), pick(), pick(), 5'(i + 1));
      ev[i] = exp_of(ps[i]);
    end
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      mult_pkt_in = ps[k < 4 ? k : 3];
      #1;
      if (c >= NS) begin
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full[%0d]: got %b want 0", c, in_ready); end
        n_tests++; if (mult_out !== ev[0]) begin n_fail++; $display("FAIL bp_hold[%0d]: got %h want %h", c, mult_out, ev[0]); end
      end
      if (in_ready) k++;
      tick();
    end
    n_tests++; if (k !== 3) begin n_fail++; $display("FAIL bp_accepts: got %0d want 3", k); end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && got < 4; c++) begin
      if (k < 4) mult_pkt_in = ps[k]; else mult_pkt_in.valid = 1'b0;
      #1;
      if (mult_out.valid) begin
        n_tests++; if (mult_out !== ev[got]) begin n_fail++; $display("FAIL bp_drain[%0d]: got %h want %h", got, mult_out, ev[got]); end
        got++;
      end
      if (mult_pkt_in.valid && in_ready) k++;
      tick();
    end
    mult_pkt_in.valid = 1'b0;
    n_tests++; if (got !== 4) begin n_fail++; $display("FAIL bp_count: got %0d want 4", got); end
    n_tests++; if (mult_out.valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b want 0", mult_out.valid); end
  endtask

  task automatic test_bubble();
    fu_pkt_t pa, pb;
    cdb_t    ea, eb;
    pa = mk_pkt(3'd1, pick(), pick(), 5'd20);
    pb = mk_pkt(3'd2, pick(), pick(), 5'd21);
    ea = exp_of(pa);
    eb = exp_of(pb);
    out_ready = 1'b0;
    mult_pkt_in = pa;      tick();
    mult_pkt_in.valid = 0; tick();
    mult_pkt_in = pb;      tick();
    mult_pkt_in.valid = 0;
    n_tests++; if (mult_out !== ea) begin n_fail++; $display("FAIL bub_hold0: got %h want %h", mult_out, ea); end
    tick();
    n_tests++; if (mult_out !== ea) begin n_fail++; $display("FAIL bub_hold1: got %h want %h", mult_out, ea); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bub_inready: got %b want 1", in_ready); end
    tick();
    out_ready = 1'b1;
    #1;
    n_tests++; if (mult_out !== ea) begin n_fail++; $display("FAIL bub_first: got %h want %h", mult_out, ea); end
    tick();
    n_tests++; if (mult_out !== eb) begin n_fail++; $display("FAIL bub_second: got %h want %h", mult_out, eb); end
    tick();
    n_tests++; if (mult_out.valid !== 1'b0) begin n_fail++; $display("FAIL bub_empty: got %b want 0", mult_out.valid); end
  endtask

  task automatic test_flush();
`ifdef FU_MULT_PERF_CNT_EN
    logic [31:0] pf0;
`endif
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      mult_pkt_in = mk_pkt(3'd0, pick(), pick(), 5'(c + 24));
      tick();
    end
    mult_pkt_in = mk_pkt(3'd3, pick(), pick(), 5'd27);
    flush = 1'b1;
`ifdef FU_MULT_PERF_CNT_EN
    pf0 = perf_flushed;
`endif
    tick();
    flush = 1'b0;
    mult_pkt_in.valid = 1'b0;
    n_tests++; if (mult_out.valid !== 1'b0) begin n_fail++; $display("FAIL fl_out: got %b want 0", mult_out.valid); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fl_inready: got %b want 1", in_ready); end
`ifdef FU_MULT_PERF_CNT_EN
    n_tests++; if (perf_flushed - pf0 !== 32'd3) begin n_fail++; $display("FAIL fl_perf: got %0d want 3", perf_flushed - pf0); end
`endif
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_tests++; if (mult_out.valid !== 1'b0) begin n_fail++; $display("FAIL fl_quiet[%0d]: got %b want 0", c, mult_out.valid); end
    end
  endtask

  task automatic test_async_reset();
    fu_pkt_t pc;
    cdb_t    ec;
    out_ready = 1'b0;
    mult_pkt_in = mk_pkt(3'd0, pick(), pick(), 5'd5); tick();
    mult_pkt_in = mk_pkt(3'd1, pick(), pick(), 5'd6); tick();
    mult_pkt_in.valid = 1'b0; tick();
    n_tests++; if (mult_out.valid !== 1'b1) begin n_fail++; $display("FAIL ar_pre: got %b want 1", mult_out.valid); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (mult_out !== '0) begin n_fail++; $display("FAIL ar_async: got %h want 0", mult_out); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ar_inready: got %b want 1", in_ready); end
    pc = mk_pkt(3'd2, pick(), pick(), 5'd7);
    ec = exp_of(pc);
    out_ready = 1'b1;
    mult_pkt_in = pc;
    tick();
    mult_pkt_in.valid = 1'b0;
    for (int c = 1; c < NS; c++) begin
      n_tests++; if (mult_out.valid !== 1'b0) begin n_fail++; $display("FAIL ar_early[%0d]: got %b want 0", c, mult_out.valid); end
      tick();
    end
    n_tests++; if (mult_out !== ec) begin n_fail++; $display("FAIL ar_first: got %h want %h", mult_out, ec); end
    tick();
    n_tests++; if (mult_out.valid !== 1'b0) begin n_fail++; $display("FAIL ar_quiet: got %b want 0", mult_out.valid); end
  endtask

  task automatic test_random();
    cdb_t q[$];
    cdb_t prev, e;
    logic prev_stall = 1'b0;
    for (int c = 0; c < 420; c++) begin
      if (c < 400 && $urandom_range(0, 3) != 0)
        mult_pkt_in = mk_pkt(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom));
      else
        mult_pkt_in.valid = 1'b0;
      out_ready = (c >= 400) || ($urandom_range(0, 2) != 0);
      #1;
      if (prev_stall) begin
        n_tests++; if (mult_out !== prev) begin n_fail++; $display("FAIL rnd_stable[%0d]: got %h want %h", c, mult_out, prev); end
      end
      if (mult_out.valid && out_ready) begin
        n_tests++;
        if (q.size() == 0) begin n_fail++; $display("FAIL rnd_spurious[%0d]: got tag %0d want none", c, mult_out.rob_tag); end
        else begin
          e = q.pop_front();
          if (mult_out !== e) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h want %h", c, mult_out, e); end
        end
      end
      if (mult_pkt_in.valid && in_ready) q.push_back(exp_of(mult_pkt_in));
      prev_stall = mult_out.valid && !out_ready;
      prev = mult_out;
      tick();
    end
    n_tests++; if (q.size() != 0) begin n_fail++; $display("FAIL rnd_drained: got %0d left want 0", q.size()); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_bubble();
    test_flush();
    test_random();
    test_async_reset();
`ifdef FU_MULT_PERF_CNT_EN
    n_tests++; if (perf_ops !== 32'(m_ops)) begin n_fail++; $display("FAIL perf_ops: got %0d want %0d", perf_ops, m_ops); end
    n_tests++; if (perf_stall !== 32'(m_stall)) begin n_fail++; $display("FAIL perf_stall: got %0d want %0d", perf_stall, m_stall); end
    n_tests++; if (perf_flushed !== 32'(m_fl)) begin n_fail++; $display("FAIL perf_flushed: got %0d want %0d", perf_flushed, m_fl); end
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
